// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter that forwards one cache-side SystemBus
// request at a time to memory, with optional invalidation (snoop) of all
// masters after a write when BUS_ARBITER_SNOOP_EN is defined.
// Ports:
//   clk, rst                 sole clock, synchronous active-high reset
//   m_rw_valid/m_rw_ready    per-master request / one-cycle completion pulse
//   m_rw_addr/we/w_mask/w_data/w_ce  packed per-master request fields
//   m_r_data                 shared read data (valid only with m_rw_ready)
//   m_inv_valid/addr/ready   invalidation channel (tied off without snoop)
//   mem_rw_*, mem_w_*        forwarded request to memory
//   mem_rw_ready, mem_r_data memory completion and read data
module bus_arbiter #(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int WIDTH      = 128,
    localparam int MASKW     = WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_rw_valid,
    output logic [N_MASTERS-1:0]          m_rw_ready,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_rw_addr,
    input  logic [N_MASTERS-1:0]          m_rw_we,
    input  logic [N_MASTERS*MASKW-1:0]    m_w_mask,
    input  logic [N_MASTERS*WIDTH-1:0]    m_w_data,
    input  logic [N_MASTERS-1:0]          m_w_ce,
    output logic [WIDTH-1:0]              m_r_data,
    output logic [N_MASTERS-1:0]          m_inv_valid,
    output logic [ADDR_WIDTH-1:0]         m_inv_addr,
    input  logic [N_MASTERS-1:0]          m_inv_ready,
    output logic                          mem_rw_valid,
    output logic [ADDR_WIDTH-1:0]         mem_rw_addr,
    output logic                          mem_rw_we,
    output logic [MASKW-1:0]              mem_w_mask,
    output logic [WIDTH-1:0]              mem_w_data,
    output logic                          mem_w_ce,
    input  logic                          mem_rw_ready,
    input  logic [WIDTH-1:0]              mem_r_data
);

    localparam int GW = (N_MASTERS > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        INV  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_d;

    logic [GW-1:0]         last_grant;
    logic [GW-1:0]         grant_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [MASKW-1:0]      mask_q;
    logic [WIDTH-1:0]      wdata_q;
    logic                  ce_q;
    logic [WIDTH-1:0]      rdata_q;

    logic                  any;
    logic [GW-1:0]         pick;
    logic [GW-1:0]         idx;

    // Round-robin search from last_grant+1 with wrap. Iterating from the
    // farthest offset down lets the nearest requester overwrite the pick.
    always_comb begin
        any  = 1'b0;
        pick = '0;
        idx  = '0;
        for (int i = N_MASTERS; i >= 1; i--) begin
            idx = GW'((int'(last_grant) + i) % N_MASTERS);
            if (m_rw_valid[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

`ifdef BUS_ARBITER_SNOOP_EN
    logic [N_MASTERS-1:0] done;

    always_ff @(posedge clk) begin
        if (rst) begin
            done <= '0;
        end else if (state == MEM && mem_rw_ready) begin
            done <= '0;
        end else if (state == INV) begin
            done <= done | m_inv_ready;
        end
    end
`else
    logic unused_inv;
    assign unused_inv = ^m_inv_ready;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GW'(N_MASTERS - 1);
            grant_q    <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            mask_q     <= '0;
            wdata_q    <= '0;
            ce_q       <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (state == IDLE && any) begin
                grant_q <= pick;
                addr_q  <= m_rw_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                we_q    <= m_rw_we[pick];
                mask_q  <= m_w_mask[int'(pick)*MASKW +: MASKW];
                wdata_q <= m_w_data[int'(pick)*WIDTH +: WIDTH];
                ce_q    <= m_w_ce[pick];
            end
            if (state == MEM && mem_rw_ready) begin
                rdata_q <= mem_r_data;
            end
            if (state == RESP) begin
                last_grant <= grant_q;
            end
        end
    end

    always_comb begin
        state_d      = state;
        m_rw_ready   = '0;
        m_r_data     = '0;
        m_inv_valid  = '0;
        m_inv_addr   = '0;
        mem_rw_valid = 1'b0;
        mem_rw_addr  = '0;
        mem_rw_we    = 1'b0;
        mem_w_mask   = '0;
        mem_w_data   = '0;
        mem_w_ce     = 1'b0;
        unique case (state)
            IDLE: begin
                if (any) state_d = MEM;
            end
            MEM: begin
                mem_rw_valid = 1'b1;
                mem_rw_addr  = addr_q;
                mem_rw_we    = we_q;
                mem_w_mask   = mask_q;
                mem_w_data   = wdata_q;
                mem_w_ce     = ce_q;
                if (mem_rw_ready) begin
`ifdef BUS_ARBITER_SNOOP_EN
                    state_d = we_q ? INV : RESP;
`else
                    state_d = RESP;
`endif
                end
            end
            INV: begin
`ifdef BUS_ARBITER_SNOOP_EN
                // Writer is invalidated too: caches do not self-update.
                m_inv_valid = ~done;
                m_inv_addr  = addr_q;
                if (&(done | m_inv_ready)) state_d = RESP;
`else
                state_d = IDLE;
`endif
            end
            RESP: begin
                for (int i = 0; i < N_MASTERS; i++) begin
                    m_rw_ready[i] = (grant_q == GW'(i));
                end
                m_r_data = rdata_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter
// (N_MASTERS=2, ADDR_WIDTH=32, WIDTH=128).
module tb_bus_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   m_rw_valid;
    logic [1:0]   m_rw_ready;
    logic [63:0]  m_rw_addr;
    logic [1:0]   m_rw_we;
    logic [31:0]  m_w_mask;
    logic [255:0] m_w_data;
    logic [1:0]   m_w_ce;
    logic [127:0] m_r_data;
    logic [1:0]   m_inv_valid;
    logic [31:0]  m_inv_addr;
    logic [1:0]   m_inv_ready;
    logic         mem_rw_valid;
    logic [31:0]  mem_rw_addr;
    logic         mem_rw_we;
    logic [15:0]  mem_w_mask;
    logic [127:0] mem_w_data;
    logic         mem_w_ce;
    logic         mem_rw_ready;
    logic [127:0] mem_r_data;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};
    localparam logic [127:0] PAT_WD = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [31:0]  A0 = 32'h0000_1000;
    localparam logic [31:0]  A1 = 32'h0000_3300;
    localparam logic [31:0]  AW = 32'h0000_2040;

    bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .m_rw_valid   (m_rw_valid),
        .m_rw_ready   (m_rw_ready),
        .m_rw_addr    (m_rw_addr),
        .m_rw_we      (m_rw_we),
        .m_w_mask     (m_w_mask),
        .m_w_data     (m_w_data),
        .m_w_ce       (m_w_ce),
        .m_r_data     (m_r_data),
        .m_inv_valid  (m_inv_valid),
        .m_inv_addr   (m_inv_addr),
        .m_inv_ready  (m_inv_ready),
        .mem_rw_valid (mem_rw_valid),
        .mem_rw_addr  (mem_rw_addr),
        .mem_rw_we    (mem_rw_we),
        .mem_w_mask   (mem_w_mask),
        .mem_w_data   (mem_w_data),
        .mem_w_ce     (mem_w_ce),
        .mem_rw_ready (mem_rw_ready),
        .mem_r_data   (mem_r_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        m_rw_valid   = '0;
        m_rw_addr    = {A1, A0};
        m_rw_we      = '0;
        m_w_mask     = '0;
        m_w_data     = '0;
        m_w_ce       = '0;
        m_inv_ready  = '0;
        mem_rw_ready = 1'b0;
        mem_r_data   = '0;
        step();
        step();
        chk("rst_mem_valid", 128'(mem_rw_valid), 128'(0));
        chk("rst_rw_ready", 128'(m_rw_ready), 128'(0));
        chk("rst_r_data", m_r_data, 128'(0));
        rst = 1'b0;
        step();
        chk("idle_mem_addr", 128'(mem_rw_addr), 128'(0));

        // single read by m0, memory answers on the second MEM cycle
        m_rw_valid = 2'b01;
        step();
        m_rw_valid = 2'b00;
        chk("rd_mem_valid", 128'(mem_rw_valid), 128'(1));
        chk("rd_mem_addr", 128'(mem_rw_addr), 128'(A0));
        chk("rd_mem_we", 128'(mem_rw_we), 128'(0));
        step();
        chk("rd_mem_hold", 128'(mem_rw_valid), 128'(1));
        chk("rd_no_early", 128'(m_rw_ready), 128'(0));
        mem_rw_ready = 1'b1;
        mem_r_data   = PAT_A5;
        step();
        mem_rw_ready = 1'b0;
        mem_r_data   = '0;
        chk("rd_ready", 128'(m_rw_ready), 128'(2'b01));
        chk("rd_data", m_r_data, PAT_A5);
        chk("rd_resp_memv", 128'(mem_rw_valid), 128'(0));
        step();
        chk("rd_ready_pulse", 128'(m_rw_ready), 128'(0));
        chk("rd_data_clr", m_r_data, 128'(0));

        // m1 granted, then reset while waiting in MEM
        m_rw_valid = 2'b10;
        step();
        m_rw_valid = 2'b00;
        chk("rm_mem_addr", 128'(mem_rw_addr), 128'(A1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rm_memv_drop", 128'(mem_rw_valid), 128'(0));
        chk("rm_no_ready", 128'(m_rw_ready), 128'(0));

        // contention after reset: 0,1,0 with no re-grant in RESP
        m_rw_valid = 2'b11;
        step();
        chk("ct0_addr", 128'(mem_rw_addr), 128'(A0));
        mem_rw_ready = 1'b1;
        step();
        mem_rw_ready = 1'b0;
        chk("ct0_ready", 128'(m_rw_ready), 128'(2'b01));
        step();
        chk("ct0_no_regrant", 128'(mem_rw_valid), 128'(0));
        step();
        chk("ct1_addr", 128'(mem_rw_addr), 128'(A1));
        mem_rw_ready = 1'b1;
        step();
        mem_rw_ready = 1'b0;
        chk("ct1_ready", 128'(m_rw_ready), 128'(2'b10));
        step();
        step();
        chk("ct2_addr", 128'(mem_rw_addr), 128'(A0));
        mem_rw_ready = 1'b1;
        step();
        mem_rw_ready = 1'b0;
        m_rw_valid   = 2'b00;
        chk("ct2_ready", 128'(m_rw_ready), 128'(2'b01));
        step();

        // write by m1 (last grant was m0)
        m_rw_addr  = {AW, A0};
        m_rw_we    = 2'b10;
        m_w_mask   = {16'hFFFF, 16'h0000};
        m_w_data   = {PAT_WD, 128'(0)};
        m_w_ce     = 2'b10;
        m_rw_valid = 2'b10;
        step();
        m_rw_valid = 2'b00;
        chk("wr_mem_we", 128'(mem_rw_we), 128'(1));
        chk("wr_mem_addr", 128'(mem_rw_addr), 128'(AW));
        chk("wr_mem_mask", 128'(mem_w_mask), 128'(16'hFFFF));
        chk("wr_mem_data", mem_w_data, PAT_WD);
        chk("wr_mem_ce", 128'(mem_w_ce), 128'(1));
        mem_rw_ready = 1'b1;
        step();
        mem_rw_ready = 1'b0;
`ifdef BUS_ARBITER_SNOOP_EN
        chk("sn_inv_v0", 128'(m_inv_valid), 128'(2'b11));
        chk("sn_inv_addr", 128'(m_inv_addr), 128'(AW));
        chk("sn_no_ready0", 128'(m_rw_ready), 128'(0));
        step();
        chk("sn_inv_v1", 128'(m_inv_valid), 128'(2'b11));
        m_inv_ready = 2'b01;
        step();
        m_inv_ready = 2'b00;
        chk("sn_inv_v2", 128'(m_inv_valid), 128'(2'b10));
        step();
        chk("sn_inv_v3", 128'(m_inv_valid), 128'(2'b10));
        m_inv_ready = 2'b10;
        step();
        m_inv_ready = 2'b00;
        chk("sn_ready", 128'(m_rw_ready), 128'(2'b10));
        chk("sn_inv_off", 128'(m_inv_valid), 128'(0));
        step();

        // simultaneous acks, write by m0
        m_rw_we    = 2'b01;
        m_rw_addr  = {A1, AW};
        m_rw_valid = 2'b01;
        step();
        m_rw_valid   = 2'b00;
        mem_rw_ready = 1'b1;
        step();
        mem_rw_ready = 1'b0;
        chk("sa_inv_v", 128'(m_inv_valid), 128'(2'b11));
        m_inv_ready = 2'b11;
        step();
        m_inv_ready = 2'b00;
        chk("sa_ready", 128'(m_rw_ready), 128'(2'b01));
        chk("sa_inv_off", 128'(m_inv_valid), 128'(0));
        step();
`else
        chk("ns_ready", 128'(m_rw_ready), 128'(2'b10));
        chk("ns_inv_v", 128'(m_inv_valid), 128'(0));
        chk("ns_inv_addr", 128'(m_inv_addr), 128'(0));
        step();
        // inv acks must be ignored without snoop
        m_rw_addr   = {A1, AW};
        m_rw_we     = 2'b01;
        m_inv_ready = 2'b11;
        m_rw_valid  = 2'b01;
        step();
        m_rw_valid   = 2'b00;
        mem_rw_ready = 1'b1;
        step();
        mem_rw_ready = 1'b0;
        m_inv_ready  = 2'b00;
        chk("ns2_ready", 128'(m_rw_ready), 128'(2'b01));
        chk("ns2_inv_v", 128'(m_inv_valid), 128'(0));
        step();
`endif
        chk("end_idle", 128'(mem_rw_valid), 128'(0));
        chk("end_ready", 128'(m_rw_ready), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
